fir_mac_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_delay_line.sv | 38 +++
 rtl/fir_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM encoding and helpers for the FIR MAC sequencer (rev 1.0)
`default_nettype none

package fir_pkg;

  localparam int TAPS    = 8;
  localparam int DW      = 16;
  localparam int PW      = 32;
  localparam int ACCW    = 35;
  localparam int MUL_LAT = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    OUT   = ST_OUT
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_delay_line.sv
// fir_delay_line: TAPS-deep sample shift register with indexed combinational read (rev 1.0)
`default_nettype none

module fir_delay_line #(
  parameter int TAPS = fir_pkg::TAPS,
  parameter int DW   = fir_pkg::DW,
  localparam int KW  = fir_pkg::clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_shift,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);
  import fir_pkg::*;

  logic [DW-1:0] r_x [TAPS];

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    if (i == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_x[i] <= '0;
        else if (i_shift) r_x[i] <= i_data;
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_x[i] <= '0;
        else if (i_shift) r_x[i] <= r_x[i-1];
      end
    end
  end

  assign o_rd_data = r_x[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR tap sequencer around an external pipelined multiplier (rev 1.0)
`default_nettype none

module fir_mac_sequencer #(
  parameter int TAPS    = fir_pkg::TAPS,
  parameter int DW      = fir_pkg::DW,
  parameter int PW      = fir_pkg::PW,
  parameter int ACCW    = fir_pkg::ACCW,
  parameter int MUL_LAT = fir_pkg::MUL_LAT,
  localparam int KW     = fir_pkg::clog2(TAPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_s_valid,
  output logic            o_s_ready,
  input  logic [DW-1:0]   i_s_data,
  input  logic            i_coef_we,
  input  logic [KW-1:0]   i_coef_addr,
  input  logic [DW-1:0]   i_coef_data,
  output logic [DW-1:0]   o_mul_a,
  output logic [DW-1:0]   o_mul_b,
  input  logic [PW-1:0]   i_mul_p,
  output logic            o_m_valid,
  input  logic            i_m_ready,
  output logic [ACCW-1:0] o_m_data
);
  import fir_pkg::*;

  state_e            r_state;
  logic [KW:0]       r_k;
  logic [DW-1:0]     r_mul_a;
  logic [DW-1:0]     r_mul_b;
  logic              r_opv;
  logic [MUL_LAT-1:0] r_tag;
  logic [ACCW-1:0]   r_acc;
  logic [DW-1:0]     r_coef [TAPS];

  logic [MUL_LAT:0]  w_tag_shift;
  logic              w_tag_out;
  logic              w_drain_done;
  logic              w_issue_more;
  logic [KW-1:0]     w_rd_idx;
  logic [DW-1:0]     w_x_rd;
  logic [DW-1:0]     w_coef_rd;
  logic              w_accept;

  assign w_accept     = (r_state == IDLE) && i_s_valid;
  assign w_rd_idx     = r_k[KW-1:0];
  assign w_coef_rd    = r_coef[w_rd_idx];
  assign w_issue_more = (r_k != (KW+1)'(TAPS));

  // Top bit is the tag retiring this cycle; the low bits are the next tag register.
  assign w_tag_shift  = {r_tag, r_opv};
  assign w_tag_out    = w_tag_shift[MUL_LAT];
  assign w_drain_done = (w_tag_shift[MUL_LAT-1:0] == '0);

  fir_delay_line #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_shift   (w_accept),
    .i_data    (i_s_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_x_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (i_coef_we) begin
      r_coef[i_coef_addr] <= i_coef_data;
    end
  end

  // Operands are registered one cycle ahead: the accept edge loads tap 0, each ISSUE edge loads tap k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_opv   <= 1'b0;
      r_tag   <= '0;
      r_acc   <= '0;
    end else begin
      r_tag <= w_tag_shift[MUL_LAT-1:0];
      if (w_tag_out) r_acc <= r_acc + ACCW'(i_mul_p);

      case (r_state)
        IDLE: begin
          if (i_s_valid) begin
            r_acc   <= '0;
            r_mul_a <= i_s_data;
            r_mul_b <= w_coef_rd;
            r_opv   <= 1'b1;
            r_k     <= (KW+1)'(1);
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue_more) begin
            r_mul_a <= w_x_rd;
            r_mul_b <= w_coef_rd;
            r_opv   <= 1'b1;
            r_k     <= r_k + (KW+1)'(1);
          end else begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_opv   <= 1'b0;
            r_k     <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drain_done) r_state <= OUT;
        end
        OUT: begin
          if (i_m_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s_ready = (r_state == IDLE);
  assign o_m_valid = (r_state == OUT);
  assign o_m_data  = r_acc;
  assign o_mul_a   = r_mul_a;
  assign o_mul_b   = r_mul_b;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed table-driven bench with a two-stage multiplier model (rev 1.0)
`default_nettype none

module tb_fir_mac_sequencer;

  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int PW   = 32;
  localparam int ACCW = 35;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            coef_we = 1'b0;
  logic [2:0]      coef_addr = '0;
  logic [DW-1:0]   coef_data = '0;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic [PW-1:0]   mul_p;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [ACCW-1:0] m_data;

  logic [PW-1:0]   p1 = '0;
  logic [PW-1:0]   p2 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    p1 <= mul_a * mul_b;
    p2 <= p1;
  end
  assign mul_p = p2;

  fir_mac_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_data    (s_data),
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_data (coef_data),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_p     (mul_p),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_m_data    (m_data)
  );

  typedef struct {
    logic [DW-1:0]   sample;
    logic [ACCW-1:0] exp;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [DW-1:0] data);
    coef_we   = 1'b1;
    coef_addr = addr[2:0];
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, output int t0);
    int n;
    n = 0;
    while (!s_ready && n < 60) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout s_ready got 0 expected 1");
    end
    s_valid = 1'b1;
    s_data  = d;
    t0      = cyc;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    int n;
    n = 0;
    while (!m_valid && n < 60) begin
      tick();
      n++;
    end
    if (!m_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_m_valid_timeout m_valid got 0 expected 1");
    end
    t = cyc;
  endtask

  initial begin
    int t0;
    int t1;
    int seen;
    logic [ACCW-1:0] hold;

    // Impulse response with coef[k]=k+1, then full-scale with all coefficients at 0xFFFF.
    for (int i = 0; i < 8; i++) begin
      vecs[i].sample = (i == 0) ? 16'd1 : 16'd0;
      vecs[i].exp    = ACCW'(i + 1);
    end
    for (int i = 8; i < 16; i++) begin
      vecs[i].sample = 16'hFFFF;
      vecs[i].exp    = ACCW'(i - 7) * 35'h0_FFFE_0001;
    end

    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hAAAA;
    repeat (3) tick();
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_mul_a",   64'(mul_a),   64'd0);
    check("rst_mul_b",   64'(mul_b),   64'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("rst_no_accept_mul_a", 64'(mul_a), 64'd0);
    check("rst_no_accept_s_ready", 64'(s_ready), 64'd1);

    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));

    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'hFFFF);
      end
      send(vecs[i].sample, t0);
      wait_valid(t1);
      check($sformatf("vec%0d", i), 64'(m_data), 64'(vecs[i].exp));
      tick();
    end

    // Latency: delay line is now {0, FFFF x7} after this sample.
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
    send(16'd0, t0);
    wait_valid(t1);
    check("latency_m_valid", 64'(t1 - t0), 64'd11);
    check("latency_data", 64'(m_data), 64'h22_FFDD);
    tick();
    check("latency_s_ready_cycle", 64'(cyc - t0), 64'd12);
    check("latency_s_ready", 64'(s_ready), 64'd1);

    // Backpressure: output held while a new sample waits.
    m_ready = 1'b0;
    send(16'd2, t0);
    wait_valid(t1);
    hold = m_data;
    check("bp_data", 64'(m_data), 64'd2 + 64'd33 * 64'd65535);
    s_valid = 1'b1;
    s_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i),  64'(m_valid), 64'd1);
      check($sformatf("bp_stable%0d", i), 64'(m_data),  64'(hold));
      check($sformatf("bp_sready%0d", i), 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    tick();
    check("bp_release_s_ready", 64'(s_ready), 64'd1);
    check("bp_release_m_valid", 64'(m_valid), 64'd0);
    tick();
    s_valid = 1'b0;
    check("bp_issue_mul_a", 64'(mul_a), 64'h1234);
    check("bp_issue_mul_b", 64'(mul_b), 64'd1);
    wait_valid(t1);
    check("bp_second_data", 64'(m_data), 64'h1234 + 64'd4 + 64'd30 * 64'd65535);
    tick();

    // Reset in the middle of ISSUE aborts the computation.
    send(16'd7, t0);
    while ((cyc - t0) < 4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_valid) seen++;
    end
    check("midrst_no_m_valid", 64'(seen), 64'd0);
    write_coef(0, 16'd5);
    send(16'd3, t0);
    wait_valid(t1);
    check("midrst_reload_data", 64'(m_data), 64'd15);
    tick();
    check("midrst_final_idle", 64'(s_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
